axi_loader_scheduler: RTL

Controller that programs and sequences a bank of N axi_master_loader instances for NoC traffic experiments.
- Accepts a descriptor stream (target loader, ID, write flag, AxLEN) and routes each descriptor into the selected loader's descriptor FIFO.
- On a run command it starts every armed loader in the same cycle and tracks completion.
- Reports run duration in clock cycles and flags completion, giving the PMU/cosim layer one control point for all loaders.

---
 rtl/axi_loader_sched_pkg.sv | 23 ++
 rtl/axi_loader_sched_if.sv | 37 +++
 rtl/axi_loader_fill_tracker.sv | 45 ++++
 rtl/axi_loader_scheduler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/axi_loader_sched_pkg.sv
// Shared types for the loader scheduler: FSM states and descriptor word.
// Field order of desc_t matches the loader FIFO word.
package axi_loader_sched_pkg;

  localparam int SCHED_ID_W = 5;

  typedef enum logic [1:0] {
    CFG,
    LAUNCH,
    RUN
  } sched_state_e;

  typedef struct packed {
    logic                  write;
    logic [7:0]            axlen;
    logic [SCHED_ID_W-1:0] id;
  } desc_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_loader_sched_if.sv
// Descriptor handshake between a config source and the loader scheduler.
// master drives descriptors, slave (scheduler) returns ready.
interface axi_loader_sched_if
  import axi_loader_sched_pkg::*;
#(
  parameter int N_LOADERS    = 4,
  parameter int MAX_ID_WIDTH = 5
);

  localparam int LW = idx_w(N_LOADERS);

  logic                    cfg_valid_i;
  logic                    cfg_ready_o;
  logic [LW-1:0]           cfg_loader_i;
  logic [MAX_ID_WIDTH-1:0] cfg_id_i;
  logic                    cfg_write_i;
  logic [7:0]              cfg_axlen_i;

  modport master (
    output cfg_valid_i,
    output cfg_loader_i,
    output cfg_id_i,
    output cfg_write_i,
    output cfg_axlen_i,
    input  cfg_ready_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_loader_i,
    input  cfg_id_i,
    input  cfg_write_i,
    input  cfg_axlen_i,
    output cfg_ready_o
  );

endinterface

// File: rtl/axi_loader_fill_tracker.sv
// Per-loader saturating descriptor fill counter plus armed flag.
// The scheduler is the only overflow guard for the loader FIFO.
module axi_loader_fill_tracker #(
  parameter int FIFO_DEPTH = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic clear_i,
  output logic full_o,
  output logic armed_o
);

  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam logic [FW-1:0] DEPTH = FW'(FIFO_DEPTH);

  logic [FW-1:0] fill_q, fill_d;
  logic          armed_q, armed_d;

  always_comb begin
    fill_d  = fill_q;
    armed_d = armed_q;
    if (clear_i) begin
      fill_d  = '0;
      armed_d = 1'b0;
    end else if (push_i) begin
      armed_d = 1'b1;
      if (fill_q < DEPTH) fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      armed_q <= armed_d;
    end
  end

  assign full_o  = (fill_q >= DEPTH);
  assign armed_o = armed_q;

endmodule

// File: rtl/axi_loader_scheduler.sv
// Programs and sequences a bank of axi_master_loader instances.
// Optional watchdog: define AXI_LOADER_SCHED_TIMEOUT_EN.
module axi_loader_scheduler
  import axi_loader_sched_pkg::*;
#(
  parameter int N_LOADERS      = 4,
  parameter int MAX_ID_WIDTH   = 5,
  parameter int FIFO_DEPTH     = 32,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  axi_loader_sched_if.slave       cfg,
  input  logic                    run_i,
  input  logic [7:0]              run_depth_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNT_WIDTH-1:0]    cycles_o,
  output logic [MAX_ID_WIDTH-1:0] ld_id_o,
  output logic                    ld_write_o,
  output logic [7:0]              ld_axlen_o,
  output logic [N_LOADERS-1:0]    ld_push_o,
  output logic [N_LOADERS-1:0]    ld_start_o,
  output logic [7:0]              ld_req_depth_o,
`ifdef AXI_LOADER_SCHED_TIMEOUT_EN
  output logic                    timeout_o,
`endif
  input  logic [N_LOADERS-1:0]    ld_idle_i
);

  localparam int LW = idx_w(N_LOADERS);
  localparam int NP = 1 << LW;

  sched_state_e state_q, state_d;
  logic [7:0]           depth_q, depth_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cycles_q, cycles_d;
  logic                 done_q, done_d;
  logic [N_LOADERS-1:0] seen_q, seen_d;
`ifdef AXI_LOADER_SCHED_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT_CYCLES);
  logic                 timeout_q, timeout_d;
`endif

  logic [N_LOADERS-1:0] full_vec, armed_vec, push_vec;
  logic [NP-1:0]        full_ext;
  logic                 in_range, ready, push, clear;
  logic                 busy;
  logic [N_LOADERS-1:0] start;
  desc_t                desc;

  // Descriptor path is pure wiring: zero latency to the loader FIFOs.
  always_comb begin
    desc       = '0;
    desc.write = cfg.cfg_write_i;
    desc.axlen = cfg.cfg_axlen_i;
    desc.id    = cfg.cfg_id_i;
  end

  assign ld_id_o    = desc.id;
  assign ld_write_o = desc.write;
  assign ld_axlen_o = desc.axlen;

  assign full_ext = NP'(full_vec);
  assign in_range = ({1'b0, cfg.cfg_loader_i} < (LW+1)'(N_LOADERS));
  assign ready    = !rst_i && (state_q == CFG) && in_range &&
                    !full_ext[cfg.cfg_loader_i];
  assign push     = cfg.cfg_valid_i && ready;
  assign push_vec = push ? (N_LOADERS'(1) << cfg.cfg_loader_i) : '0;

  assign cfg.cfg_ready_o = ready;
  assign ld_push_o       = push_vec;

  for (genvar g = 0; g < N_LOADERS; g++) begin : g_fill
    axi_loader_fill_tracker #(
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fill (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (push_vec[g]),
      .clear_i(clear),
      .full_o (full_vec[g]),
      .armed_o(armed_vec[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    done_d   = 1'b0;
    seen_d   = seen_q;
    clear    = 1'b0;
    busy     = 1'b0;
    start    = '0;
`ifdef AXI_LOADER_SCHED_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      CFG: begin
        if (run_i) begin
`ifdef AXI_LOADER_SCHED_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          // A push in the same cycle joins this run.
          if ((armed_vec | push_vec) != '0) begin
            depth_d = run_depth_i;
            cnt_d   = '0;
            state_d = LAUNCH;
          end else begin
            done_d   = 1'b1;
            cycles_d = '0;
          end
        end
      end
      LAUNCH: begin
        busy    = 1'b1;
        start   = armed_vec;
        cnt_d   = CNT_WIDTH'(1);
        seen_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        start  = armed_vec;
        cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        seen_d = seen_q | (armed_vec & ~ld_idle_i);
        // Idle only counts once the loader has been seen busy.
        if ((seen_q & ld_idle_i & armed_vec) == armed_vec) begin
          cycles_d = cnt_q;
          done_d   = 1'b1;
          clear    = 1'b1;
          seen_d   = '0;
          state_d  = CFG;
        end
`ifdef AXI_LOADER_SCHED_TIMEOUT_EN
        else if (cnt_q == TMO) begin
          timeout_d = 1'b1;
          cycles_d  = TMO;
          done_d    = 1'b1;
          clear     = 1'b1;
          seen_d    = '0;
          state_d   = CFG;
        end
`endif
      end
      default: state_d = CFG;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= CFG;
      depth_q  <= '0;
      cnt_q    <= '0;
      cycles_q <= '0;
      done_q   <= 1'b0;
      seen_q   <= '0;
`ifdef AXI_LOADER_SCHED_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      done_q   <= done_d;
      seen_q   <= seen_d;
`ifdef AXI_LOADER_SCHED_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  assign busy_o         = busy;
  assign done_o         = done_q;
  assign cycles_o       = cycles_q;
  assign ld_start_o     = start;
  assign ld_req_depth_o = depth_q;
`ifdef AXI_LOADER_SCHED_TIMEOUT_EN
  assign timeout_o = timeout_q;
`endif

endmodule
